adc_frame_capture: RTL and testbench

- Parametrised multi-channel successor to the single-channel 12-bit ADC shift-in block.
- Owns its own frame FSM: drives the shared active-low chip select and shifts N_CH serial ADC lines in parallel.
- Discards leading and trailing pad bits, and presents all channels as one packed word with a valid/ready handshake and an overrun flag.
- Sits between the ADC pins and the sample FIFO / USB packetiser.

---
 rtl/adc_frame_capture.sv | 149 ++++++++++++++
 tb/tb_adc_frame_capture.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_capture.sv
// Multi-channel serial ADC frame capture. Drives the shared chip select, shifts
// N_CH serial lines in parallel on the falling edge of sclk, drops the pad bits,
// and hands each complete sample set to the consumer with valid/ready and a
// sticky overrun flag.
module adc_frame_capture #(
   parameter int unsigned N_CH       = 2,
   parameter int unsigned DATA_W     = 12,
   parameter int unsigned LEAD_BITS  = 4,
   parameter int unsigned TRAIL_BITS = 0,
   parameter int unsigned QUIET_CYC  = 2
) (
   input  logic                     sclk_i,
   input  logic                     reset_i,
   input  logic                     enable_i,
   input  logic                     single_i,
   input  logic                     start_i,
   input  logic                     clr_ovr_i,
   input  logic [N_CH-1:0]          sdata_i,
   output logic                     cs_n_o,
   output logic [N_CH*DATA_W-1:0]   data_o,
   output logic                     valid_o,
   input  logic                     ready_i,
   output logic                     overrun_o,
   output logic                     busy_o
);

   localparam int unsigned Frame   = LEAD_BITS + DATA_W + TRAIL_BITS;
   localparam int unsigned BitCntW = $clog2(Frame) + 1;
   localparam int unsigned QCntW   = $clog2(QUIET_CYC) + 1;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StConv  = 2'd1;
   localparam logic [1:0] StQuiet = 2'd2;

   logic [1:0]                    state_q, state_d;
   logic                          cs_n_q, cs_n_d;
   logic [BitCntW-1:0]            bit_cnt_q, bit_cnt_d;
   logic [QCntW-1:0]              q_cnt_q, q_cnt_d;
   logic [N_CH-1:0][DATA_W-1:0]   sh_q, sh_d;
   logic [N_CH*DATA_W-1:0]        data_q, data_d;
   logic                          valid_q, valid_d;
   logic                          overrun_q, overrun_d;
   logic                          busy_q;
   logic                          in_data;
   logic                          frame_done;

   // Only the payload window of the frame feeds the shift registers.
   assign in_data = (32'(bit_cnt_q) >= LEAD_BITS) && (32'(bit_cnt_q) < LEAD_BITS + DATA_W);

   // Frame FSM, shift-in and output handshake next-state logic.
   always_comb begin
      state_d    = state_q;
      cs_n_d     = cs_n_q;
      bit_cnt_d  = bit_cnt_q;
      q_cnt_d    = q_cnt_q;
      sh_d       = sh_q;
      data_d     = data_q;
      valid_d    = valid_q;
      overrun_d  = overrun_q & ~clr_ovr_i;
      frame_done = 1'b0;

      if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end

      case (state_q)
         StIdle: begin
            if (enable_i && (!single_i || start_i)) begin
               state_d   = StConv;
               cs_n_d    = 1'b0;
               bit_cnt_d = '0;
            end
         end
         StConv: begin
            if (in_data) begin
               for (int i = 0; i < int'(N_CH); i++) begin
                  sh_d[i] = {sh_q[i][DATA_W-2:0], sdata_i[i]};
               end
            end
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BitCntW'(Frame - 1)) begin
               cs_n_d     = 1'b1;
               q_cnt_d    = '0;
               state_d    = StQuiet;
               frame_done = 1'b1;
            end
         end
         StQuiet: begin
            q_cnt_d = q_cnt_q + 1'b1;
            if (q_cnt_q == QCntW'(QUIET_CYC - 1)) begin
               if (enable_i && !single_i) begin
                  state_d   = StConv;
                  cs_n_d    = 1'b0;
                  bit_cnt_d = '0;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: begin
            state_d = StIdle;
            cs_n_d  = 1'b1;
         end
      endcase

      // A finished frame lands only if the output slot is free or being freed now;
      // otherwise it is dropped and the sticky overrun wins over a clear.
      if (frame_done) begin
         if (!valid_q || ready_i) begin
            data_d  = sh_d;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   // State registers, updated on the falling edge of the serial clock.
   always_ff @(negedge sclk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= StIdle;
         cs_n_q    <= 1'b1;
         bit_cnt_q <= '0;
         q_cnt_q   <= '0;
         sh_q      <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cs_n_q    <= cs_n_d;
         bit_cnt_q <= bit_cnt_d;
         q_cnt_q   <= q_cnt_d;
         sh_q      <= sh_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
         busy_q    <= (state_d != StIdle);
      end
   end

   assign cs_n_o    = cs_n_q;
   assign data_o    = data_q;
   assign valid_o   = valid_q;
   assign overrun_o = overrun_q;
   assign busy_o    = busy_q;

endmodule

// File: tb/tb_adc_frame_capture.sv
// Bench for adc_frame_capture: an ADC model drives 16-bit frames while cs_n is
// low and queues the expected 24-bit word; a monitor pops and compares on every
// accepted transfer.
module tb_adc_frame_capture;

   logic        sclk = 1'b0;
   logic        reset, enable, single, start, clr_ovr, ready;
   logic [1:0]  sdata;
   logic        cs_n_o, valid_o, overrun_o, busy_o;
   logic [23:0] data_o;

   int          errors = 0;
   int          checks = 0;
   int          acc_cnt = 0;
   logic [23:0] exp_q[$];
   logic [23:0] exp_v;
   bit          fixed_pat = 1'b0;
   logic [15:0] w0, w1;

   adc_frame_capture dut (
      .sclk_i    (sclk),
      .reset_i   (reset),
      .enable_i  (enable),
      .single_i  (single),
      .start_i   (start),
      .clr_ovr_i (clr_ovr),
      .sdata_i   (sdata),
      .cs_n_o    (cs_n_o),
      .data_o    (data_o),
      .valid_o   (valid_o),
      .ready_i   (ready),
      .overrun_o (overrun_o),
      .busy_o    (busy_o)
   );

   always #5 sclk = ~sclk;

   // ADC model: presents bit idx on the rising edge so the DUT samples it on the fall.
   initial begin : adc_model
      int idx;
      idx   = 0;
      sdata = '0;
      forever begin
         @(posedge sclk);
         if (cs_n_o) begin
            idx = 0;
         end else begin
            if (idx == 0) begin
               if (fixed_pat) begin
                  w0 = 16'h0ABC;
                  w1 = 16'h053F;
               end else begin
                  w0 = 16'($urandom);
                  w1 = 16'($urandom);
               end
               exp_q.push_back({w1[11:0], w0[11:0]});
            end
            if (idx < 16) sdata = {w1[15-idx], w0[15-idx]};
            idx++;
         end
      end
   end

   // Scoreboard: a transfer happens on the next falling edge when valid and ready.
   always @(posedge sclk) begin
      if (!reset && valid_o && ready) begin
         checks++;
         acc_cnt++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got data=%h, expected no transfer", data_o);
         end else begin
            exp_v = exp_q.pop_front();
            if (data_o !== exp_v) begin
               errors++;
               $display("FAIL scoreboard_data: got %h, expected %h", data_o, exp_v);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   // what: 0 = idle with cs_n high, 1 = cs_n low, 2 = valid high.
   task automatic wait_for(input int what, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 300; n++) begin
         @(negedge sclk);
         #1;
         case (what)
            0:       if (!busy_o && cs_n_o) ok = 1'b1;
            1:       if (!cs_n_o) ok = 1'b1;
            2:       if (valid_o) ok = 1'b1;
            default: ok = 1'b1;
         endcase
         if (ok) break;
      end
   endtask

   task automatic pulse_start();
      @(negedge sclk); #1 start = 1'b1;
      @(negedge sclk); #1 start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b0; single = 1'b0; start = 1'b0;
      clr_ovr = 1'b0; ready = 1'b0;
      repeat (3) @(negedge sclk);
      #1;
      checks++; if (cs_n_o !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b, expected 1", cs_n_o); end
      checks++; if (data_o !== 24'h0) begin errors++; $display("FAIL reset_data: got %h, expected 0", data_o); end
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", valid_o); end
      checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b, expected 0", overrun_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy_o); end
      reset = 1'b0;
   endtask

   task automatic test_continuous();
      bit ok;
      int low, high, period;
      fixed_pat = 1'b1; single = 1'b0; ready = 1'b1; enable = 1'b1;
      wait_for(1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL cont_start: cs_n never fell, expected fall"); end
      low = 1;
      for (int n = 0; n < 100; n++) begin
         @(negedge sclk); #1;
         if (!cs_n_o) low++; else break;
      end
      high = 1;
      for (int n = 0; n < 100; n++) begin
         @(negedge sclk); #1;
         if (cs_n_o) high++; else break;
      end
      checks++; if (low != 16) begin errors++; $display("FAIL cont_cs_low: got %0d edges, expected 16", low); end
      checks++; if (high != 2) begin errors++; $display("FAIL cont_cs_high: got %0d edges, expected 2", high); end
      wait_for(2, ok);
      checks++; if (data_o !== 24'h53FABC) begin errors++; $display("FAIL cont_data: got %h, expected 53fabc", data_o); end
      @(negedge sclk); #1;
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL cont_valid_pulse: got %b, expected 0", valid_o); end
      period = 1;
      for (int n = 0; n < 100; n++) begin
         @(negedge sclk); #1;
         period++;
         if (valid_o) break;
      end
      checks++; if (period != 18) begin errors++; $display("FAIL cont_period: got %0d edges, expected 18", period); end
      enable = 1'b0;
      wait_for(0, ok);
      fixed_pat = 1'b0;
   endtask

   task automatic test_single();
      int falls, low, a0;
      logic prev;
      single = 1'b1; enable = 1'b1; ready = 1'b1;
      for (int shot = 0; shot < 2; shot++) begin
         a0 = acc_cnt; falls = 0; low = 0; prev = 1'b1;
         @(negedge sclk); #1 start = 1'b1;
         for (int n = 0; n < 60; n++) begin
            @(negedge sclk); #1 start = 1'b0;
            if (!cs_n_o) low++;
            if (!cs_n_o && prev) falls++;
            prev = cs_n_o;
         end
         checks++; if (falls != 1) begin errors++; $display("FAIL single_frames: got %0d, expected 1", falls); end
         checks++; if (low != 16) begin errors++; $display("FAIL single_cs_low: got %0d, expected 16", low); end
         checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single_busy: got %b, expected 0", busy_o); end
         checks++; if (acc_cnt - a0 != 1) begin errors++; $display("FAIL single_accepts: got %0d, expected 1", acc_cnt - a0); end
      end
   endtask

   task automatic test_overrun();
      bit ok;
      logic [23:0] exp_a;
      single = 1'b1; enable = 1'b1; ready = 1'b0; exp_a = '0;
      pulse_start();
      wait_for(0, ok);
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL ovr_first_valid: got %b, expected 1", valid_o); end
      checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL ovr_first_flag: got %b, expected 0", overrun_o); end
      checks++; if (exp_q.size() != 1) begin errors++; $display("FAIL ovr_queue1: got %0d, expected 1", exp_q.size()); end
      if (exp_q.size() > 0) exp_a = exp_q[0];
      pulse_start();
      wait_for(0, ok);
      checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b, expected 1", overrun_o); end
      checks++; if (data_o !== exp_a) begin errors++; $display("FAIL ovr_data_held: got %h, expected %h", data_o, exp_a); end
      checks++; if (exp_q.size() != 2) begin errors++; $display("FAIL ovr_queue2: got %0d, expected 2", exp_q.size()); end
      if (exp_q.size() == 2) exp_q.delete(1);
      ready = 1'b1;
      @(negedge sclk); #1;
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL ovr_drain: got valid=%b, expected 0", valid_o); end
      checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b, expected 1", overrun_o); end
      clr_ovr = 1'b1;
      @(negedge sclk); #1 clr_ovr = 1'b0;
      checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b, expected 0", overrun_o); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      single = 1'b0; ready = 1'b0; enable = 1'b1;
      wait_for(2, ok);
      repeat (17) @(negedge sclk);
      #1 ready = 1'b1;
      @(negedge sclk); #1;
      ready = 1'b0; enable = 1'b0;
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b, expected 1", valid_o); end
      checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b, expected 0", overrun_o); end
      checks++; if (exp_q.size() != 1) begin errors++; $display("FAIL b2b_queue: got %0d, expected 1", exp_q.size()); end
      if (exp_q.size() > 0) begin
         checks++;
         if (data_o !== exp_q[0]) begin errors++; $display("FAIL b2b_data: got %h, expected %h", data_o, exp_q[0]); end
      end
      ready = 1'b1;
      wait_for(0, ok);
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b, expected 0", valid_o); end
   endtask

   task automatic test_enable_drop();
      bit ok;
      int low;
      single = 1'b0; ready = 1'b1; enable = 1'b1;
      wait_for(1, ok);
      low = 1;
      for (int n = 0; n < 100; n++) begin
         @(negedge sclk); #1;
         if (low == 5) enable = 1'b0;
         if (!cs_n_o) low++; else break;
      end
      checks++; if (low != 16) begin errors++; $display("FAIL endrop_cs_low: got %0d, expected 16", low); end
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL endrop_valid: got %b, expected 1", valid_o); end
      @(negedge sclk); #1;
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL endrop_quiet: got busy=%b, expected 1", busy_o); end
      @(negedge sclk); #1;
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL endrop_idle: got busy=%b, expected 0", busy_o); end
      checks++; if (cs_n_o !== 1'b1) begin errors++; $display("FAIL endrop_cs: got %b, expected 1", cs_n_o); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int low;
      single = 1'b0; ready = 1'b1; enable = 1'b1;
      wait_for(1, ok);
      repeat (8) @(negedge sclk);
      #3 reset = 1'b1;
      #1;
      checks++; if (cs_n_o !== 1'b1) begin errors++; $display("FAIL rstmid_cs: got %b, expected 1", cs_n_o); end
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b, expected 0", valid_o); end
      checks++; if (data_o !== 24'h0) begin errors++; $display("FAIL rstmid_data: got %h, expected 0", data_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b, expected 0", busy_o); end
      exp_q.delete();
      @(negedge sclk); #1 reset = 1'b0;
      wait_for(1, ok);
      low = 1;
      for (int n = 0; n < 100; n++) begin
         @(negedge sclk); #1;
         if (!cs_n_o) low++; else break;
      end
      enable = 1'b0;
      checks++; if (low != 16) begin errors++; $display("FAIL rstmid_cs_low: got %0d, expected 16", low); end
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL rstmid_frame: got valid=%b, expected 1", valid_o); end
      wait_for(0, ok);
   endtask

   initial begin
      test_reset();
      test_continuous();
      test_single();
      test_overrun();
      test_back_to_back();
      test_enable_drop();
      test_reset_mid();
      repeat (4) @(negedge sclk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL final_queue: got %0d pending frames, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
